regbank_sequencer: RTL
======================

Name: regbank_sequencer

Overview:
- Multi-cycle controller that sequences the 8x16 register bank (ports in/out, ldX, Tx, ir) on behalf of two requesters.
- Arbitrates between the requesters round-robin and accepts one register-transfer command at a time.
- Expands each command into the required Tx (read) and ldX (write) cycles, using internal temporaries t0 and t1.
- Returns read data on a response port.

Parameters:
- WIDTH, 16, data width of bank registers and all data ports
- AW, 3, register-select width; the bank holds 2**AW registers

Ports:
- clk  in  1  rising-edge clock shared with the register bank
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has a command
- req0_ready  out  1  requester 0 command accepted this cycle when valid is also high
- req0_op  in  2  00 LDI, 01 RD, 10 MOV, 11 SWAP
- req0_rd  in  AW  destination register
- req0_rs  in  AW  source register
- req0_imm  in  WIDTH  immediate value for LDI
- req1_valid, req1_ready, req1_op, req1_rd, req1_rs, req1_imm: same as requester 0
- resp_valid  out  1  one-cycle pulse, read data valid
- resp_data  out  WIDTH  read data
- resp_id  out  1  requester that issued the RD
- busy  out  1  high whenever state != IDLE
- bank_in  out  WIDTH  drives the bank's in port
- bank_out  in  WIDTH  the bank's out port; valid combinationally while Tx=1
- ldX  out  1  bank write enable; reg[ir] <= in at the rising edge
- Tx  out  1  bank transmit enable
- ir  out  AW  bank register select

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low. It is sampled only at the rising edge of clk.
- Reset values: state=IDLE, t0=0, t1=0, last_grant=1 (so req0 wins the first contention), resp_valid=0, resp_data=0, resp_id=0.
- Bank outputs after reset: ldX=0, Tx=0, ir=0, bank_in=0. busy=0.
- Reset mid-command: the command is abandoned immediately and no further bank writes occur. A partially executed SWAP leaves the bank partially updated; this is intended.
- Bank output encoding: ldX, Tx, ir and bank_in are decoded from the state register and latched fields only. There is no combinational path from req inputs to bank outputs.
- Bank output invariants: ldX and Tx are never both 1. Outside WR/RD states ldX=0, Tx=0, ir=0, bank_in=0.
- Arbitration: reqN_ready = (state==IDLE) && grant==N. Ready is combinational from state, last_grant and both valids.
- Grant rules:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant; all readies are 0.
  - last_grant updates on acceptance.
- Acceptance: at the accepting edge, latch op, rd, rs, imm and id, then leave IDLE. Request inputs may change freely afterwards.
- States: IDLE, RD1, RD2, WR1, WR2, RESP.
- IDLE: accept a command, then go to:
  - LDI -> WR1
  - RD, MOV, SWAP -> RD1
- RD1: Tx=1, ir=rs; t0 <= bank_out. Next state:
  - SWAP -> RD2
  - MOV -> WR1
  - RD -> RESP
- RD2: Tx=1, ir=rd; t1 <= bank_out. Next state: WR1.
- WR1: ldX=1, ir=rd. bank_in = imm for LDI, else t0. Next state:
  - SWAP -> WR2
  - otherwise -> IDLE
- WR2: ldX=1, ir=rs, bank_in=t1. Next state: IDLE.
- RESP: resp_valid=1, resp_data=t0, resp_id=latched id, held for exactly one cycle. Next state: IDLE.
  - No backpressure on the response.
  - resp_data holds its value until the next RESP.
- Busy cycles, from the accepting edge to the next cycle in which ready can be high:
  - LDI: 1
  - RD: 2
  - MOV: 2
  - SWAP: 4
- Back-to-back: the cycle after returning to IDLE may accept a new command. Maximum throughput is one LDI every 2 cycles.
- rd==rs: commands are executed literally. MOV and SWAP with rd==rs leave the register value unchanged.
- Every op code is legal; there is no error path.

Test Plan:
- Reset with both valids high and rst_n=0 for 2 cycles -> all outputs 0 and busy=0. After release, req0 is granted first.
- req0 LDI rd=2 imm=16'h0080 -> exactly one cycle with ldX=1, ir=2, bank_in=16'h0080. Bank reg2 reads 16'h0080 afterwards.
- req1 RD rs=2 following the LDI -> one Tx cycle with ir=2. Next cycle resp_valid=1, resp_data=16'h0080, resp_id=1.
- Preload reg3=16'h1111 and reg5=16'h2222, then SWAP rd=3 rs=5 -> 4 busy cycles, sequence Tx5, Tx3, ld3, ld5. Afterwards reg3=16'h2222, reg5=16'h1111.
- Both requesters continuously valid with LDI -> grants alternate 0,1,0,1. No requester waits more than one command.
- Assert rst_n=0 during RD2 of a SWAP -> no ldX pulse follows, and the controller returns to IDLE with reset values.

Source files
------------

// File: rtl/regbank_sequencer.sv
// Round-robin sequencer that expands LDI/RD/MOV/SWAP commands from two requesters
// into Tx/ldX cycles on an 8x16 register bank, returning RD data on a response port.
module regbank_sequencer #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [AW-1:0]    req0_rd,
    input  logic [AW-1:0]    req0_rs,
    input  logic [WIDTH-1:0] req0_imm,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [AW-1:0]    req1_rd,
    input  logic [AW-1:0]    req1_rs,
    input  logic [WIDTH-1:0] req1_imm,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             busy,
    output logic [WIDTH-1:0] bank_in,
    input  logic [WIDTH-1:0] bank_out,
    output logic             ldX,
    output logic             Tx,
    output logic [AW-1:0]    ir
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        RESP = 3'd5
    } state_t;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_MOV  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    state_t           state_r, state_s;
    logic [1:0]       op_r;
    logic [AW-1:0]    rd_r, rs_r;
    logic [WIDTH-1:0] imm_r, t0_r, t1_r, resp_data_r;
    logic             id_r, last_grant_r, resp_valid_r, resp_id_r;
    logic             grant_id_s, accept_s;
    logic [1:0]       sel_op_s;
    logic [AW-1:0]    sel_rd_s, sel_rs_s;
    logic [WIDTH-1:0] sel_imm_s;

    // Round-robin grant; ready is held low while reset is asserted
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        accept_s   = rst_n && (state_r == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept_s && !grant_id_s;
        req1_ready = accept_s && grant_id_s;
        if (grant_id_s) begin
            sel_op_s  = req1_op;
            sel_rd_s  = req1_rd;
            sel_rs_s  = req1_rs;
            sel_imm_s = req1_imm;
        end else begin
            sel_op_s  = req0_op;
            sel_rd_s  = req0_rd;
            sel_rs_s  = req0_rs;
            sel_imm_s = req0_imm;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = (sel_op_s == OP_LDI) ? WR1 : RD1;
                end else begin
                    state_s = IDLE;
                end
            end
            RD1: begin
                case (op_r)
                    OP_SWAP: state_s = RD2;
                    OP_MOV:  state_s = WR1;
                    OP_RD:   state_s = RESP;
                    default: state_s = IDLE;
                endcase
            end
            RD2:     state_s = WR1;
            WR1:     state_s = (op_r == OP_SWAP) ? WR2 : IDLE;
            WR2:     state_s = IDLE;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Command latch, temporaries and registered response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r         <= 2'b00;
            rd_r         <= {AW{1'b0}};
            rs_r         <= {AW{1'b0}};
            imm_r        <= {WIDTH{1'b0}};
            id_r         <= 1'b0;
            t0_r         <= {WIDTH{1'b0}};
            t1_r         <= {WIDTH{1'b0}};
            last_grant_r <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_data_r  <= {WIDTH{1'b0}};
            resp_id_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                op_r         <= sel_op_s;
                rd_r         <= sel_rd_s;
                rs_r         <= sel_rs_s;
                imm_r        <= sel_imm_s;
                id_r         <= grant_id_s;
                last_grant_r <= grant_id_s;
            end
            if (state_r == RD1) begin
                t0_r <= bank_out;
            end
            if (state_r == RD2) begin
                t1_r <= bank_out;
            end
            resp_valid_r <= (state_s == RESP);
            // RESP is only entered from RD1, so bank_out here is the value t0 captures
            if (state_s == RESP) begin
                resp_data_r <= bank_out;
                resp_id_r   <= id_r;
            end
        end
    end

    // Bank controls decoded from state and latched fields only
    always_comb begin
        ldX     = 1'b0;
        Tx      = 1'b0;
        ir      = {AW{1'b0}};
        bank_in = {WIDTH{1'b0}};
        busy    = (state_r != IDLE);
        case (state_r)
            RD1: begin
                Tx = 1'b1;
                ir = rs_r;
            end
            RD2: begin
                Tx = 1'b1;
                ir = rd_r;
            end
            WR1: begin
                ldX     = 1'b1;
                ir      = rd_r;
                bank_in = (op_r == OP_LDI) ? imm_r : t0_r;
            end
            WR2: begin
                ldX     = 1'b1;
                ir      = rs_r;
                bank_in = t1_r;
            end
            default: begin
                ldX = 1'b0;
            end
        endcase
    end

    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_id    = resp_id_r;

endmodule
